// File: rtl/n64_audio_i2s_tx_if.sv
// Parallel sample handshake into the N64 audio I2S serializer.
// One {left,right} pair moves on VALID & READY.
interface n64_audio_i2s_tx_if;
  logic [15:0] PDATA_LEFT_i;
  logic [15:0] PDATA_RIGHT_i;
  logic        PDATA_VALID_i;
  logic        PDATA_READY_o;

  // Producer side: drives samples, observes the buffer-empty flag
  modport master (
    output PDATA_LEFT_i, PDATA_RIGHT_i, PDATA_VALID_i,
    input  PDATA_READY_o
  );

  // Serializer side
  modport slave (
    input  PDATA_LEFT_i, PDATA_RIGHT_i, PDATA_VALID_i,
    output PDATA_READY_o
  );
endinterface

// File: rtl/n64_audio_i2s_tx.sv
// N64 audio serial transmitter: 16-bit stereo, 32 SCLK per frame,
// I2S one-bit delay. Outputs change only on the MCLK edge that drives
// SCLK low, so a receiver sampling on SCLK rise sees stable data.
module n64_audio_i2s_tx #(
  parameter int SCLK_HALF_DIV = 4
) (
  input  logic                MCLK_i,
  input  logic                RST_i,
  input  logic                EN_i,
  n64_audio_i2s_tx_if.slave   s_pdata,
  output logic                SCLK_o,
  output logic                LRCLK_o,
  output logic                SDATA_o,
  output logic                UNDERRUN_o
);
  localparam int              DW     = $clog2(SCLK_HALF_DIV);
  localparam logic [DW-1:0]   DIV_TC = DW'(SCLK_HALF_DIV - 1);

  logic [15:0]   r_buf_l, r_buf_r;
  logic          r_full;
  logic [31:0]   r_shift;
  logic [DW-1:0] r_div;
  logic [4:0]    r_cnt;
  logic          r_sclk, r_lrclk, r_sdata, r_underrun;
  logic          r_run;   // frame in progress; low only while halted/idle

  logic          w_adv, w_tc, w_fall, w_wrap, w_boundary, w_halt, w_take;
  logic [4:0]    w_cnt_nxt, w_idx;

  // Idle serializer is kicked off directly by EN_i so the first SCLK rise
  // lands SCLK_HALF_DIV edges after enable, same as after reset.
  assign w_adv      = r_run | EN_i;
  assign w_tc       = w_adv && (r_div == DIV_TC);
  assign w_fall     = w_tc && r_sclk;
  assign w_wrap     = w_fall && (r_cnt == 5'd31);
  assign w_boundary = w_wrap && EN_i;
  assign w_halt     = w_wrap && !EN_i;
  assign w_take     = s_pdata.PDATA_VALID_i && !r_full;
  assign w_cnt_nxt  = r_cnt + 5'd1;
  // Frame word bit for slot n is [32-n], i.e. -n modulo 32
  assign w_idx      = 5'd0 - w_cnt_nxt;

  assign s_pdata.PDATA_READY_o = ~r_full;
  assign SCLK_o     = r_sclk;
  assign LRCLK_o    = r_lrclk;
  assign SDATA_o    = r_sdata;
  assign UNDERRUN_o = r_underrun;

  // One-entry holding buffer: fill on handshake, drain at frame load
  always_ff @(posedge MCLK_i or posedge RST_i) begin
    if (RST_i) begin
      r_full  <= 1'b0;
      r_buf_l <= '0;
      r_buf_r <= '0;
    end else if (w_take) begin
      r_full  <= 1'b1;
      r_buf_l <= s_pdata.PDATA_LEFT_i;
      r_buf_r <= s_pdata.PDATA_RIGHT_i;
    end else if (w_boundary && r_full) begin
      r_full  <= 1'b0;
    end
  end

  // Frame word: reload from buffer at the boundary, else repeat last frame
  always_ff @(posedge MCLK_i or posedge RST_i) begin
    if (RST_i)                       r_shift <= '0;
    else if (w_boundary && r_full)   r_shift <= {r_buf_l, r_buf_r};
  end

  // Half-period divider and SCLK toggle; run flag drops on halt
  always_ff @(posedge MCLK_i or posedge RST_i) begin
    if (RST_i) begin
      r_div  <= '0;
      r_sclk <= 1'b0;
      r_run  <= 1'b0;
    end else if (w_adv) begin
      r_run <= !w_halt;
      if (w_tc) begin
        r_div  <= '0;
        r_sclk <= ~r_sclk;
      end else begin
        r_div  <= r_div + DW'(1);
      end
    end
  end

  // Bit slot counter, word select and serial data on SCLK falling edge
  always_ff @(posedge MCLK_i or posedge RST_i) begin
    if (RST_i) begin
      r_cnt   <= 5'd31;
      r_lrclk <= 1'b0;
      r_sdata <= 1'b0;
    end else if (w_fall) begin
      if (w_halt) begin
        r_lrclk <= 1'b0;
        r_sdata <= 1'b0;
      end else begin
        r_cnt   <= w_cnt_nxt;
        r_lrclk <= ~w_cnt_nxt[4];
        // Slot 0 carries the previous frame's right LSB (pre-load value)
        r_sdata <= (w_cnt_nxt == 5'd0) ? r_shift[0] : r_shift[w_idx];
      end
    end
  end

  // Underrun flag, registered so it lands the cycle after the boundary
  always_ff @(posedge MCLK_i or posedge RST_i) begin
    if (RST_i) r_underrun <= 1'b0;
    else       r_underrun <= w_boundary && !r_full;
  end
endmodule
